// File: rtl/wave_pop_pacer_pkg.sv
// Shared types and constants for the waveform pop pacer.
package wave_pop_pacer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W      = 32;

    // Pops closer than two cycles apart would overlap the one-cycle read latency.
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REWIND = 3'd1,
        S_POP    = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter reload for a requested period: max(period, MIN_PERIOD) - 1.
    function automatic logic [CNT_W-1:0] reload_value(input logic [CNT_W-1:0] period);
        logic [CNT_W-1:0] peff;
        peff = (period < MIN_PERIOD) ? MIN_PERIOD : period;
        return peff - CNT_W'(1);
    endfunction

endpackage

// File: rtl/wave_pop_pacer_counter.sv
// Period down-counter: loads a reload value, counts down while enabled and
// flags the last cycle of the interval when the count sits at 1.
module pacer_counter
    import wave_pop_pacer_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; stop at zero so an idle counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/wave_pop_pacer.sv
// Paces pops from an upstream waveform BRAM and captures the returned samples.
//
// state  | meaning
// IDLE   | waiting for start
// REWIND | rewind pulse to upstream, pass counters cleared
// POP    | pop pulse to upstream, period counter reloaded
// HOLD   | waiting out the remainder of the pop period
// DONE   | one-cycle done pulse, then back to IDLE
module wave_pop_pacer
    import wave_pop_pacer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [CNT_W-1:0]  period,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] wave_in,
    output logic              rewind,
    output logic              pop,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic [ADDR_W:0]   sample_idx,
    output logic              busy,
    output logic              done
);

    localparam int IW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic              rewind_q, rewind_d;
    logic              pop_q, pop_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic              sample_valid_q, sample_valid_d;
    logic [IW-1:0]     sample_idx_q, sample_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cap_pend_q, cap_pend_d;
    logic [IW-1:0]     len_q, len_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [IW-1:0]     pop_cnt_q, pop_cnt_d;

    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_expired;

    pacer_counter #(.W(CNT_W)) u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (reload_value(per_q)),
        .en         (cnt_en),
        .expired    (cnt_expired)
    );

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d        = state_q;
        sample_out_d   = sample_out_q;
        sample_idx_d   = sample_idx_q;
        sample_valid_d = 1'b0;
        len_d          = len_q;
        per_d          = per_q;
        pop_cnt_d      = pop_cnt_q;
        cnt_load       = 1'b0;
        cnt_en         = 1'b0;

        // The word requested by last cycle's pop is on wave_in now; it still
        // lands after the FSM has moved on to REWIND or DONE.
        if (cap_pend_q && !stop) begin
            sample_out_d   = wave_in;
            sample_idx_d   = sample_idx_q + IW'(1);
            sample_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = length;
                    per_d   = period;
                    state_d = (length != '0) ? S_REWIND : S_DONE;
                end
            end
            S_REWIND: begin
                state_d = S_POP;
            end
            S_POP: begin
                cnt_load  = 1'b1;
                pop_cnt_d = pop_cnt_q + IW'(1);
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_expired) begin
                    if (pop_cnt_q < len_q) begin
                        state_d = S_POP;
                    end else if (loop_en) begin
                        per_d   = period;
                        state_d = S_REWIND;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
        end

        // A new pass restarts the index even if the previous pass's final
        // capture completes on the same edge.
        if (state_d == S_REWIND) begin
            sample_idx_d = '0;
            pop_cnt_d    = '0;
        end

        rewind_d   = (state_d == S_REWIND);
        pop_d      = (state_d == S_POP);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        cap_pend_d = pop_q && !stop;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rewind_q       <= 1'b0;
            pop_q          <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cap_pend_q     <= 1'b0;
            len_q          <= '0;
            per_q          <= '0;
            pop_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            rewind_q       <= rewind_d;
            pop_q          <= pop_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cap_pend_q     <= cap_pend_d;
            len_q          <= len_d;
            per_q          <= per_d;
            pop_cnt_q      <= pop_cnt_d;
        end
    end

    assign rewind       = rewind_q;
    assign pop          = pop_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_wave_pop_pacer.sv
// Directed bench for wave_pop_pacer: expected event cycles are queued when a
// run is started and checked as the DUT emits rewind/pop/sample_valid/done.
module tb_wave_pop_pacer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    typedef struct {
        int          c;
        logic [31:0] d;
        int          idx;
    } vexp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start, stop, loop_en;
    logic [31:0]       period;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] wave_in;
    logic              rewind, pop, sample_valid, busy, done;
    logic [DATA_W-1:0] sample_out;
    logic [ADDR_W:0]   sample_idx;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int bram_addr;

    int    exp_rew[$];
    int    exp_pop[$];
    int    exp_done[$];
    vexp_t exp_val[$];

    wave_pop_pacer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .period       (period),
        .length       (length),
        .wave_in      (wave_in),
        .rewind       (rewind),
        .pop          (pop),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wdat(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_0111;
    endfunction

    // Upstream BRAM: data appears one cycle after pop.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bram_addr <= 0;
            wave_in   <= '0;
        end else if (rewind) begin
            bram_addr <= 0;
        end else if (pop) begin
            wave_in   <= wdat(bram_addr);
            bram_addr <= bram_addr + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every event must match the head of its queue.
    always @(negedge clk) begin
        int    got;
        vexp_t v;
        if (reset_n) begin
            if (rewind) begin
                if (exp_rew.size() > 0) got = exp_rew.pop_front(); else got = -1;
                chk("rewind_cycle", cyc, got);
                chk("rewind_idx", sample_idx, 0);
            end
            if (pop) begin
                if (exp_pop.size() > 0) got = exp_pop.pop_front(); else got = -1;
                chk("pop_cycle", cyc, got);
            end
            if (done) begin
                if (exp_done.size() > 0) got = exp_done.pop_front(); else got = -1;
                chk("done_cycle", cyc, got);
            end
            if (sample_valid) begin
                if (exp_val.size() > 0) v = exp_val.pop_front();
                else v = '{c: -1, d: 32'h0, idx: -1};
                chk("valid_cycle", cyc, v.c);
                chk("valid_data", sample_out, v.d);
                chk("valid_idx", sample_idx, v.idx);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic push_pop(input int pc, input int k);
        exp_pop.push_back(pc);
        exp_val.push_back('{c: pc + 2, d: wdat(k), idx: k + 1});
    endtask

    // One full pass starting with rewind at cycle r; nxt is the cycle the FSM
    // leaves HOLD after the last pop (rewind or done cycle).
    task automatic push_pass(input int r, input int peff, input int len, output int nxt);
        int last;
        exp_rew.push_back(r);
        for (int k = 0; k < len; k++) push_pop(r + 1 + k * peff, k);
        last = r + 1 + (len - 1) * peff;
        nxt  = last + peff;
    endtask

    task automatic pulse_start(output int t0);
        t0    = cyc;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int b = 0;
        while ((exp_rew.size() + exp_pop.size() + exp_val.size() + exp_done.size()) != 0 && b < 300) begin
            next_cycle();
            b++;
        end
        repeat (6) next_cycle();
        chk(tag, exp_rew.size() + exp_pop.size() + exp_val.size() + exp_done.size(), 0);
    endtask

    initial begin
        int t0, nxt;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        period  = 32'd4;
        length  = 11'd3;
        repeat (3) next_cycle();

        chk("rst_pop", pop, 0);
        chk("rst_rewind", rewind, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_idx", sample_idx, 0);
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // One-shot, period 4, length 3; inputs changed mid-pass must not matter.
        pulse_start(t0);
        push_pass(t0 + 1, 4, 3, nxt);
        exp_done.push_back(nxt);
        step_to(t0 + 3);
        period = 32'd9;
        length = 11'd1;
        step_to(t0 + 4);
        period = 32'd4;
        length = 11'd3;
        drain("oneshot_drain");
        chk("oneshot_idx", sample_idx, 3);
        chk("oneshot_data", sample_out, wdat(2));
        chk("oneshot_busy", busy, 0);

        // period 0 and period 1 clamp to two-cycle spacing.
        period = 32'd0;
        pulse_start(t0);
        push_pass(t0 + 1, 2, 3, nxt);
        exp_done.push_back(nxt);
        drain("period0_drain");
        chk("period0_idx", sample_idx, 3);

        period = 32'd1;
        length = 11'd2;
        pulse_start(t0);
        push_pass(t0 + 1, 2, 2, nxt);
        exp_done.push_back(nxt);
        drain("period1_drain");

        // Loop mode; new period is picked up only at the wrap.
        period  = 32'd3;
        length  = 11'd2;
        loop_en = 1'b1;
        pulse_start(t0);
        push_pass(t0 + 1, 3, 2, nxt);
        step_to(t0 + 3);
        period = 32'd5;
        push_pass(nxt, 5, 2, nxt);
        step_to(nxt - 2);
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        chk("loop_stop_busy", busy, 0);
        loop_en = 1'b0;
        drain("loop_drain");
        chk("loop_idx", sample_idx, 2);

        // Stop in HOLD after the 2nd pop; a start while busy is ignored.
        period = 32'd4;
        length = 11'd3;
        pulse_start(t0);
        exp_rew.push_back(t0 + 1);
        push_pop(t0 + 2, 0);
        push_pop(t0 + 6, 1);
        step_to(t0 + 3);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        step_to(t0 + 9);
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        drain("stop_drain");
        chk("stop_hold_data", sample_out, wdat(1));
        chk("stop_hold_idx", sample_idx, 2);

        // start and stop together from IDLE stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        next_cycle();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        drain("startstop_drain");

        // Zero length: done only, busy for exactly one cycle.
        length = 11'd0;
        pulse_start(t0);
        exp_done.push_back(t0 + 1);
        chk("zero_busy_on", busy, 1);
        next_cycle();
        chk("zero_busy_off", busy, 0);
        drain("zero_drain");

        // Asynchronous reset mid-HOLD, then a fresh run from rewind.
        length = 11'd3;
        pulse_start(t0);
        exp_rew.push_back(t0 + 1);
        push_pop(t0 + 2, 0);
        step_to(t0 + 5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sample_out", sample_out, 0);
        chk("mid_rst_sample_idx", sample_idx, 0);
        chk("mid_rst_pop", pop, 0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        chk("post_rst_pop", pop, 0);
        chk("post_rst_busy", busy, 0);
        pulse_start(t0);
        push_pass(t0 + 1, 4, 3, nxt);
        exp_done.push_back(nxt);
        drain("replay_drain");
        chk("replay_idx", sample_idx, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
